// File: rtl/sa_inst_dispatcher_if.sv
// Instruction intake and per-unit command handshake bundle for the systolic array dispatcher.
interface sa_inst_dispatcher_if #(
    parameter int unsigned INST_WIDTH    = 16,
    parameter int unsigned BUF_ID_WIDTH  = 2,
    parameter int unsigned MEM_LOC_WIDTH = 10
);
    logic                     inst_valid;
    logic                     inst_ready;
    logic [INST_WIDTH-1:0]    inst;
    logic [3:0]               cmd_valid;
    logic [3:0]               cmd_ready;
    logic [BUF_ID_WIDTH-1:0]  cmd_buf_id;
    logic [MEM_LOC_WIDTH-1:0] cmd_mem_loc;
    logic [3:0]               unit_done;

    // Dispatcher side.
    modport slave (
        input  inst_valid, inst, cmd_ready, unit_done,
        output inst_ready, cmd_valid, cmd_buf_id, cmd_mem_loc
    );

    // Instruction source / execution units side.
    modport master (
        output inst_valid, inst, cmd_ready, unit_done,
        input  inst_ready, cmd_valid, cmd_buf_id, cmd_mem_loc
    );
endinterface

// File: rtl/sa_inst_dispatcher.sv
// Buffered instruction front end: FIFO intake, in-order decode, hazard-checked dispatch
// of LD/ST/GEMM/DRAIN commands with one in-flight command per unit.
module sa_inst_dispatcher #(
    parameter int unsigned INST_WIDTH    = 16,
    parameter int unsigned OPCODE_WIDTH  = 4,
    parameter int unsigned BUF_ID_WIDTH  = 2,
    parameter int unsigned MEM_LOC_WIDTH = 10,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter logic [OPCODE_WIDTH-1:0] OPC_LD    = OPCODE_WIDTH'(4'b0010),
    parameter logic [OPCODE_WIDTH-1:0] OPC_ST    = OPCODE_WIDTH'(4'b0011),
    parameter logic [OPCODE_WIDTH-1:0] OPC_GEMM  = OPCODE_WIDTH'(4'b0100),
    parameter logic [OPCODE_WIDTH-1:0] OPC_DRAIN = OPCODE_WIDTH'(4'b0101)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_reading_i,
    sa_inst_dispatcher_if.slave           bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          idle_o,
    output logic                          err_illegal_o,
    output logic [OPCODE_WIDTH-1:0]       err_opcode_o
);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned FIELD_W = OPCODE_WIDTH + BUF_ID_WIDTH + MEM_LOC_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HAZARD, S_ISSUE} state_e;

    state_e                    state_q, state_d;
    logic [INST_WIDTH-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      ready_q, idle_q;
    logic [3:0]                dec_unit_q, dec_unit_d;
    logic [BUF_ID_WIDTH-1:0]   dec_buf_q, dec_buf_d;
    logic [MEM_LOC_WIDTH-1:0]  dec_mem_q, dec_mem_d;
    logic [3:0]                cmd_valid_q, cmd_valid_d;
    logic [3:0]                outstanding_q, outstanding_d;
    logic                      err_illegal_q, err_illegal_d;
    logic [OPCODE_WIDTH-1:0]   err_opcode_q, err_opcode_d;

    logic                      push, pop, empty, blocked;
    logic [3:0]                hs, hz_mask, head_unit;
    logic [INST_WIDTH-1:0]     head;
    logic [OPCODE_WIDTH-1:0]   head_op;

    assign push    = bus.inst_valid & ready_q;
    assign pop     = (state_q == S_FETCH);
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign head_op = head[FIELD_W-1 -: OPCODE_WIDTH];
    assign hs      = cmd_valid_q & bus.cmd_ready;

    always_comb begin
        head_unit = 4'b0000;
        case (head_op)
            OPC_LD:    head_unit = 4'b0001;
            OPC_ST:    head_unit = 4'b0010;
            OPC_GEMM:  head_unit = 4'b0100;
            OPC_DRAIN: head_unit = 4'b1000;
            default:   head_unit = 4'b0000;
        endcase
    end

    // Per-unit hazard: which outstanding units a command to that unit must wait behind.
    always_comb begin
        hz_mask[0] = outstanding_q[0];
        hz_mask[1] = outstanding_q[1] | outstanding_q[2] | outstanding_q[3];
        hz_mask[2] = outstanding_q[2] | outstanding_q[0];
        hz_mask[3] = outstanding_q[3] | outstanding_q[2];
        blocked    = |(dec_unit_q & hz_mask);
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);
        outstanding_d = (outstanding_q & ~bus.unit_done) | hs;
    end

    always_comb begin
        state_d       = state_q;
        dec_unit_d    = dec_unit_q;
        dec_buf_d     = dec_buf_q;
        dec_mem_d     = dec_mem_q;
        cmd_valid_d   = cmd_valid_q;
        err_illegal_d = err_illegal_q;
        err_opcode_d  = err_opcode_q;
        case (state_q)
            S_IDLE: begin
                if (start_reading_i && !empty) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (|head_unit) begin
                    dec_unit_d = head_unit;
                    dec_buf_d  = head[MEM_LOC_WIDTH +: BUF_ID_WIDTH];
                    dec_mem_d  = head[MEM_LOC_WIDTH-1:0];
                    state_d    = S_HAZARD;
                end else begin
                    err_illegal_d = 1'b1;
                    if (!err_illegal_q) err_opcode_d = head_op;
                    state_d = S_IDLE;
                end
            end
            S_HAZARD: begin
                if (!blocked) begin
                    cmd_valid_d = dec_unit_q;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (|hs) begin
                    cmd_valid_d = 4'b0000;
                    state_d     = (start_reading_i && !empty) ? S_FETCH : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Storage carries no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.inst;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            ready_q       <= 1'b1;
            idle_q        <= 1'b1;
            dec_unit_q    <= '0;
            dec_buf_q     <= '0;
            dec_mem_q     <= '0;
            cmd_valid_q   <= '0;
            outstanding_q <= '0;
            err_illegal_q <= 1'b0;
            err_opcode_q  <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_q + PTR_W'(push);
            rd_ptr_q      <= rd_ptr_q + PTR_W'(pop);
            count_q       <= count_d;
            ready_q       <= (count_d != CNT_W'(FIFO_DEPTH));
            idle_q        <= (count_d == '0) && (state_d == S_IDLE) && (outstanding_d == '0);
            dec_unit_q    <= dec_unit_d;
            dec_buf_q     <= dec_buf_d;
            dec_mem_q     <= dec_mem_d;
            cmd_valid_q   <= cmd_valid_d;
            outstanding_q <= outstanding_d;
            err_illegal_q <= err_illegal_d;
            err_opcode_q  <= err_opcode_d;
        end
    end

    assign bus.inst_ready  = ready_q;
    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.cmd_buf_id  = dec_buf_q;
    assign bus.cmd_mem_loc = dec_mem_q;
    assign fifo_count_o    = count_q;
    assign idle_o          = idle_q;
    assign err_illegal_o   = err_illegal_q;
    assign err_opcode_o    = err_opcode_q;
endmodule

// File: tb/tb_sa_inst_dispatcher.sv
// Self-checking bench for sa_inst_dispatcher: vector table plus scoreboard of expected commands.
module tb_sa_inst_dispatcher;
    localparam logic [3:0] OP_LD = 4'b0010, OP_ST = 4'b0011, OP_GEMM = 4'b0100, OP_DRAIN = 4'b0101;

    typedef struct packed {
        logic [3:0] unit;
        logic [1:0] bid;
        logic [9:0] mem;
    } exp_t;

    typedef struct {
        logic [15:0] inst;
        exp_t        exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_reading = 1'b0;
    logic [3:0] fifo_count;
    logic       idle, err_illegal;
    logic [3:0] err_opcode;

    int   checks = 0;
    int   errors = 0;
    int   handshakes = 0;
    logic auto_done = 1'b0;
    logic [3:0] pend_done = 4'b0000;
    exp_t sb[$];
    vec_t tbl[8];

    sa_inst_dispatcher_if #(.INST_WIDTH(16), .BUF_ID_WIDTH(2), .MEM_LOC_WIDTH(10)) bus ();

    sa_inst_dispatcher dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_reading_i (start_reading),
        .bus             (bus),
        .fifo_count_o    (fifo_count),
        .idle_o          (idle),
        .err_illegal_o   (err_illegal),
        .err_opcode_o    (err_opcode)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] b, input logic [9:0] m);
        return {op, b, m};
    endfunction

    function automatic exp_t ex(input logic [3:0] u, input logic [1:0] b, input logic [9:0] m);
        exp_t e;
        e.unit = u; e.bid = b; e.mem = m;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: observe handshakes at the falling edge, then step past the rising edge.
    task automatic tick();
        logic [3:0] hs;
        exp_t e;
        @(negedge clk);
        hs = bus.cmd_valid & bus.cmd_ready;
        if (hs != 4'b0000) begin
            handshakes++;
            if (sb.size() == 0) begin
                chk("sb_unexpected_cmd", 32'({hs, bus.cmd_buf_id, bus.cmd_mem_loc}), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("sb_cmd", 32'({hs, bus.cmd_buf_id, bus.cmd_mem_loc}), 32'(e));
            end
            if (auto_done) pend_done = hs;
        end
        @(posedge clk);
        #1;
        bus.unit_done = pend_done;
        pend_done = 4'b0000;
    endtask

    task automatic push_word(input logic [15:0] w);
        bus.inst_valid = 1'b1;
        bus.inst = w;
        tick();
        bus.inst_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (!(sb.size() == 0 && idle && bus.cmd_valid == 4'b0000) && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(n < budget), 32'h1);
    endtask

    initial begin
        int   h0;
        int   n;
        logic gemm_seen;

        tbl[0] = '{mk(OP_LD,    2'd0, 10'h001), ex(4'b0001, 2'd0, 10'h001)};
        tbl[1] = '{mk(OP_ST,    2'd1, 10'h0A2), ex(4'b0010, 2'd1, 10'h0A2)};
        tbl[2] = '{mk(OP_GEMM,  2'd2, 10'h133), ex(4'b0100, 2'd2, 10'h133)};
        tbl[3] = '{mk(OP_DRAIN, 2'd3, 10'h2C4), ex(4'b1000, 2'd3, 10'h2C4)};
        tbl[4] = '{mk(OP_GEMM,  2'd1, 10'h055), ex(4'b0100, 2'd1, 10'h055)};
        tbl[5] = '{mk(OP_LD,    2'd3, 10'h3FE), ex(4'b0001, 2'd3, 10'h3FE)};
        tbl[6] = '{mk(OP_DRAIN, 2'd0, 10'h200), ex(4'b1000, 2'd0, 10'h200)};
        tbl[7] = '{mk(OP_ST,    2'd2, 10'h111), ex(4'b0010, 2'd2, 10'h111)};

        bus.inst_valid = 1'b0;
        bus.inst       = 16'h0;
        bus.cmd_ready  = 4'b0000;
        bus.unit_done  = 4'b0000;

        // Reset values
        tick(); tick();
        chk("rst_inst_ready", 32'(bus.inst_ready), 32'h1);
        chk("rst_idle", 32'(idle), 32'h1);
        chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'h0);
        chk("rst_fifo_count", 32'(fifo_count), 32'h0);
        chk("rst_err", 32'({err_illegal, err_opcode}), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single LD: command appears three cycles after the push edge
        start_reading = 1'b1;
        bus.cmd_ready = 4'b1111;
        sb.push_back(ex(4'b0001, 2'd1, 10'h005));
        push_word(mk(OP_LD, 2'd1, 10'h005));
        tick(); chk("lat_n1", 32'(bus.cmd_valid), 32'h0);
        tick(); chk("lat_n2", 32'(bus.cmd_valid), 32'h0);
        tick(); chk("lat_n3", 32'({bus.cmd_valid, bus.cmd_buf_id, bus.cmd_mem_loc}), 32'({4'b0001, 2'd1, 10'h005}));
        tick(); tick(); tick();
        chk("ld_outstanding_not_idle", 32'(idle), 32'h0);
        bus.unit_done = 4'b0001;
        tick();
        tick();
        chk("ld_done_idle", 32'(idle), 32'h1);

        // GEMM must wait behind an outstanding LD
        sb.push_back(ex(4'b0001, 2'd0, 10'h010));
        sb.push_back(ex(4'b0100, 2'd3, 10'h020));
        push_word(mk(OP_LD, 2'd0, 10'h010));
        push_word(mk(OP_GEMM, 2'd3, 10'h020));
        gemm_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.cmd_valid[2]) gemm_seen = 1'b1;
        end
        chk("gemm_held_by_ld", 32'({gemm_seen, bus.cmd_valid}), 32'h0);
        bus.unit_done = 4'b0001;
        tick();
        chk("gemm_done_edge", 32'(bus.cmd_valid), 32'h0);
        tick();
        chk("gemm_after_done", 32'(bus.cmd_valid), 32'h4);
        tick();
        bus.unit_done = 4'b0100;
        tick();
        wait_drain("hazard_drain", 20);

        // Fill FIFO with dispatch disabled, then drain the vector table in order
        auto_done = 1'b1;
        start_reading = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sb.push_back(tbl[i].exp);
            push_word(tbl[i].inst);
        end
        chk("full_count", 32'(fifo_count), 32'h8);
        chk("full_not_ready", 32'(bus.inst_ready), 32'h0);
        push_word(mk(OP_LD, 2'd1, 10'h3C3));
        chk("full_9th_rejected", 32'(fifo_count), 32'h8);
        chk("full_no_dispatch", 32'(bus.cmd_valid), 32'h0);
        h0 = handshakes;
        start_reading = 1'b1;
        wait_drain("table_drain", 300);
        chk("table_handshakes", 32'(handshakes - h0), 32'h8);
        chk("table_count_empty", 32'(fifo_count), 32'h0);
        chk("table_ready", 32'(bus.inst_ready), 32'h1);

        // Illegal opcodes are dropped; only the first one is recorded
        push_word(mk(4'hF, 2'd0, 10'h000));
        sb.push_back(ex(4'b0010, 2'd2, 10'h155));
        push_word(mk(OP_ST, 2'd2, 10'h155));
        wait_drain("illegal_drain", 40);
        chk("illegal_sticky", 32'(err_illegal), 32'h1);
        chk("illegal_first_op", 32'(err_opcode), 32'hF);
        push_word(mk(4'h0, 2'd1, 10'h001));
        for (int i = 0; i < 8; i++) tick();
        chk("illegal_second_keeps", 32'({err_illegal, err_opcode}), 32'h1F);
        chk("illegal_no_cmd", 32'(sb.size()), 32'h0);

        // Back-pressure during ISSUE with start_reading toggling
        bus.cmd_ready = 4'b0000;
        sb.push_back(ex(4'b1000, 2'd2, 10'h3AB));
        push_word(mk(OP_DRAIN, 2'd2, 10'h3AB));
        n = 0;
        while (bus.cmd_valid == 4'b0000 && n < 20) begin tick(); n++; end
        chk("stall_reached_issue", 32'(n < 20), 32'h1);
        for (int i = 0; i < 5; i++) begin
            start_reading = i[0];
            tick();
            chk("stall_stable", 32'({bus.cmd_valid, bus.cmd_buf_id, bus.cmd_mem_loc}), 32'({4'b1000, 2'd2, 10'h3AB}));
        end
        h0 = handshakes;
        bus.cmd_ready = 4'b1000;
        tick();
        bus.cmd_ready = 4'b0000;
        chk("stall_released", 32'(bus.cmd_valid), 32'h0);
        chk("stall_single_issue", 32'(handshakes - h0), 32'h1);
        start_reading = 1'b1;
        wait_drain("stall_drain", 20);

        // Reset in the middle of ISSUE with four words still queued
        push_word(mk(OP_LD, 2'd0, 10'h0F0));
        push_word(mk(OP_ST, 2'd1, 10'h0F1));
        push_word(mk(OP_GEMM, 2'd2, 10'h0F2));
        push_word(mk(OP_DRAIN, 2'd3, 10'h0F3));
        push_word(mk(OP_LD, 2'd0, 10'h0F4));
        n = 0;
        while (bus.cmd_valid == 4'b0000 && n < 20) begin tick(); n++; end
        chk("mid_issue_valid", 32'(bus.cmd_valid), 32'h1);
        chk("mid_issue_count", 32'(fifo_count), 32'h4);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_cmd_valid", 32'(bus.cmd_valid), 32'h0);
        chk("mid_rst_count", 32'(fifo_count), 32'h0);
        chk("mid_rst_idle", 32'(idle), 32'h1);
        rst_n = 1'b1;
        tick();

        // Normal operation after the mid-flight reset
        bus.cmd_ready = 4'b1111;
        sb.push_back(ex(4'b0001, 2'd3, 10'h3FF));
        push_word(mk(OP_LD, 2'd3, 10'h3FF));
        wait_drain("post_rst_drain", 20);
        chk("post_rst_err_cleared", 32'({err_illegal, err_opcode}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
